// File: rtl/sensor_hub_if.sv
// Host-side request/response bundle of the sensor hub.
interface sensor_hub_if;
    logic       enable;
    logic [7:0] request_command;
    logic [7:0] request_address;
    logic       response_valid;
    logic [7:0] response_command;
    logic [7:0] response_value;
    logic       busy;

    modport master (
        output enable, request_command, request_address,
        input  response_valid, response_command, response_value, busy
    );

    modport slave (
        input  enable, request_command, request_address,
        output response_valid, response_command, response_value, busy
    );
endinterface

// File: rtl/sensor_hub.sv
// Multi-channel DHT11 command hub: host requests, continuous sensing,
// checksum validation, read timeout and round-robin service of due channels.
module sensor_hub #(
    parameter int unsigned NUM_SENSORS        = 4,
    parameter int unsigned LOOP_PERIOD_CYCLES = 100000000,
    parameter int unsigned TIMEOUT_CYCLES     = 2500000
) (
    input  logic                       clock,
    input  logic                       reset,
    sensor_hub_if.slave                host,
    input  logic [40*NUM_SENSORS-1:0]  sensor_data,
    input  logic [NUM_SENSORS-1:0]     sensor_error,
    input  logic [NUM_SENSORS-1:0]     sensor_done,
    output logic [NUM_SENSORS-1:0]     sensor_enable
);
    localparam int unsigned CW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_SEND, ST_GAP} state_t;
    typedef enum logic [1:0] {MODE_OFF, MODE_TEMP, MODE_HUM} mode_t;

    state_t               state, state_nxt;
    mode_t                mode [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] due, due_nxt;

    logic                 enable_prev, pending;
    logic [7:0]           req_cmd, req_addr;
    logic [31:0]          period_cnt, tmo_cnt;
    logic                 period_wrap, tmo_hit, gap_cnt;
    logic [CW-1:0]        rr_ptr, cur_ch, req_ch, due_ch, sel_ch;
    logic                 cur_req, cur_temp, sel_req, sel_temp, serve_due, due_found;
    logic [7:0]           cur_cmd, resp_cmd, resp_val;

    logic                 addr_ok;
    mode_t                req_mode;
    logic                 mode_wr, due_wr_val;
    mode_t                mode_wr_val;
    logic                 imm, resp_load;
    logic [7:0]           imm_cmd, imm_val, resp_cmd_nxt, resp_val_nxt;

    logic [39:0]          words [NUM_SENSORS];
    logic [39:0]          cur_word;
    logic [7:0]           chk_sum, read_cmd, read_val;
    logic                 fault, read_exit;

    assign req_ch   = req_addr[CW-1:0];
    assign addr_ok  = 32'(req_addr) < NUM_SENSORS;
    assign req_mode = mode[req_ch];

    assign period_wrap = (period_cnt == LOOP_PERIOD_CYCLES - 1);
    assign tmo_hit     = (state == ST_READ) && (tmo_cnt == TIMEOUT_CYCLES - 1);

    assign host.response_valid   = (state == ST_SEND);
    assign host.response_command = resp_cmd;
    assign host.response_value   = resp_val;
    assign host.busy             = pending | (state != ST_IDLE);

    // Decode the sensor bus into per-channel words.
    always_comb begin
        for (int unsigned k = 0; k < NUM_SENSORS; k++) begin
            words[k] = sensor_data[40*k +: 40];
        end
    end

    // Only the addressed channel is enabled, and only while reading.
    always_comb begin
        sensor_enable = '0;
        if (state == ST_READ) begin
            sensor_enable[cur_ch] = 1'b1;
        end
    end

    // Round-robin search for the next due channel after the last one served.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        due_found = 1'b0;
        due_ch    = rr_ptr;
        for (int unsigned i = 1; i <= NUM_SENSORS; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_SENSORS) begin
                idx = idx - NUM_SENSORS;
            end
            if (!due_found && due[idx[CW-1:0]]) begin
                due_found = 1'b1;
                due_ch    = idx[CW-1:0];
            end
        end
    end

    // Evaluate the in-flight read: exit condition, fault and response fields.
    always_comb begin
        cur_word  = words[cur_ch];
        chk_sum   = cur_word[39:32] + cur_word[31:24] + cur_word[23:16] + cur_word[15:8];
        read_exit = sensor_done[cur_ch] | sensor_error[cur_ch] | tmo_hit;
        fault     = sensor_error[cur_ch] | tmo_hit | (chk_sum != cur_word[7:0]);
        read_cmd  = 8'h45;
        read_val  = 8'h45;
        if (!cur_req) begin
            if (!fault) begin
                read_cmd = cur_temp ? 8'h0D : 8'h0E;
                read_val = cur_temp ? cur_word[23:16] : cur_word[39:32];
            end
        end else if (cur_cmd == 8'h00) begin
            read_cmd = fault ? 8'h1F : 8'h07;
            read_val = read_cmd;
        end else if (!fault) begin
            read_cmd = (cur_cmd == 8'h01) ? 8'h09 : 8'h08;
            read_val = (cur_cmd == 8'h01) ? cur_word[23:16] : cur_word[39:32];
        end
    end

    // Next-state logic and IDLE dispatch decisions.
    always_comb begin
        state_nxt    = state;
        sel_ch       = cur_ch;
        sel_req      = 1'b0;
        sel_temp     = 1'b0;
        serve_due    = 1'b0;
        mode_wr      = 1'b0;
        mode_wr_val  = MODE_OFF;
        due_wr_val   = 1'b0;
        imm          = 1'b0;
        imm_cmd      = '0;
        imm_val      = '0;
        resp_load    = 1'b0;
        resp_cmd_nxt = resp_cmd;
        resp_val_nxt = resp_val;
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    sel_req = 1'b1;
                    sel_ch  = req_ch;
                    if (!addr_ok) begin
                        imm = 1'b1; imm_cmd = 8'hEF; imm_val = 8'hEF;
                    end else if (req_cmd > 8'h06) begin
                        imm = 1'b1; imm_cmd = 8'h45; imm_val = 8'h45;
                    end else begin
                        case (req_cmd)
                            8'h00, 8'h01, 8'h02: begin
                                if (req_mode != MODE_OFF) begin
                                    imm = 1'b1; imm_cmd = 8'hFF; imm_val = 8'hFF;
                                end else begin
                                    state_nxt = ST_READ;
                                end
                            end
                            8'h03, 8'h04: begin
                                mode_wr     = 1'b1;
                                mode_wr_val = (req_cmd == 8'h03) ? MODE_TEMP : MODE_HUM;
                                due_wr_val  = 1'b1;
                                imm = 1'b1; imm_cmd = 8'h0C; imm_val = req_addr;
                            end
                            default: begin
                                if (req_mode == ((req_cmd == 8'h05) ? MODE_TEMP : MODE_HUM)) begin
                                    mode_wr     = 1'b1;
                                    mode_wr_val = MODE_OFF;
                                    due_wr_val  = 1'b0;
                                    imm = 1'b1; imm_cmd = 8'h0F; imm_val = req_addr;
                                end else begin
                                    imm = 1'b1; imm_cmd = 8'hAA; imm_val = 8'hAA;
                                end
                            end
                        endcase
                    end
                end else if (due_found) begin
                    sel_ch    = due_ch;
                    sel_temp  = (mode[due_ch] == MODE_TEMP);
                    serve_due = 1'b1;
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (read_exit) begin
                    state_nxt    = ST_SEND;
                    resp_load    = 1'b1;
                    resp_cmd_nxt = read_cmd;
                    resp_val_nxt = read_val;
                end
            end
            ST_SEND: state_nxt = ST_GAP;
            ST_GAP:  if (gap_cnt) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (imm) begin
            state_nxt    = ST_SEND;
            resp_load    = 1'b1;
            resp_cmd_nxt = imm_cmd;
            resp_val_nxt = imm_val;
        end
    end

    // Due flags: service clears, period wrap sets, mode commands override both.
    always_comb begin
        due_nxt = due;
        if (state == ST_SEND && !cur_req) begin
            due_nxt[cur_ch] = 1'b0;
        end
        for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
            if (period_wrap && mode[i] != MODE_OFF) begin
                due_nxt[i] = 1'b1;
            end
        end
        if (mode_wr) begin
            due_nxt[req_ch] = due_wr_val;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Datapath: request latch, modes, counters, current job and response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable_prev <= 1'b0;
            pending     <= 1'b0;
            req_cmd     <= '0;
            req_addr    <= '0;
            for (int unsigned i = 0; i < NUM_SENSORS; i++) mode[i] <= MODE_OFF;
            due         <= '0;
            period_cnt  <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= 1'b0;
            rr_ptr      <= CW'(NUM_SENSORS - 1);
            cur_ch      <= '0;
            cur_req     <= 1'b0;
            cur_temp    <= 1'b0;
            cur_cmd     <= '0;
            resp_cmd    <= '0;
            resp_val    <= '0;
        end else begin
            enable_prev <= host.enable;
            if (host.enable && !enable_prev && !pending) begin
                pending  <= 1'b1;
                req_cmd  <= host.request_command;
                req_addr <= host.request_address;
            end else if (state == ST_SEND && cur_req) begin
                pending <= 1'b0;
            end
            if (mode_wr) mode[req_ch] <= mode_wr_val;
            due        <= due_nxt;
            period_cnt <= period_wrap ? '0 : period_cnt + 32'd1;
            tmo_cnt    <= (state == ST_READ) ? tmo_cnt + 32'd1 : '0;
            gap_cnt    <= (state == ST_GAP) ? ~gap_cnt : 1'b0;
            if (serve_due) rr_ptr <= due_ch;
            if (state == ST_IDLE && state_nxt != ST_IDLE) begin
                cur_ch   <= sel_ch;
                cur_req  <= sel_req;
                cur_temp <= sel_temp;
                cur_cmd  <= req_cmd;
            end
            if (resp_load) begin
                resp_cmd <= resp_cmd_nxt;
                resp_val <= resp_val_nxt;
            end
        end
    end
endmodule

// File: tb/tb_sensor_hub.sv
// Randomized bench for sensor_hub with a rule-level reference model.
module tb_sensor_hub;
    localparam int NS  = 4;
    localparam int LP  = 200;
    localparam int TMO = 50;

    typedef struct { logic [7:0] c; logic [7:0] v; int t; } rsp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [40*NS-1:0] sensor_data;
    logic [NS-1:0]    sensor_error = '0;
    logic [NS-1:0]    sensor_done  = '0;
    logic [NS-1:0]    sensor_enable;

    sensor_hub_if host_bus ();

    sensor_hub #(
        .NUM_SENSORS(NS),
        .LOOP_PERIOD_CYCLES(LP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .host(host_bus),
        .sensor_data(sensor_data),
        .sensor_error(sensor_error),
        .sensor_done(sensor_done),
        .sensor_enable(sensor_enable)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int en_reads = 0;
    int last_len = 0;
    int last_ch  = -1;
    int onehot_bad = 0;
    logic prev_valid = 1'b0;
    int en_cnt [NS];
    rsp_t got_q [$];

    logic [39:0] ch_data [NS];
    int ch_delay [NS];
    bit ch_err [NS];
    int mode_m [NS];

    task automatic check(input string tag, input int got, input int expv);
        n_total++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
    endtask

    always_comb begin
        for (int k = 0; k < NS; k++) sensor_data[40*k +: 40] = ch_data[k];
    end

    always @(posedge clock) cyc++;

    // Sensor responder: done/error after ch_delay enabled cycles; 0 means never.
    always @(negedge clock) begin
        for (int k = 0; k < NS; k++) begin
            if (sensor_enable[k]) begin
                en_cnt[k]++;
            end else begin
                if (en_cnt[k] > 0) begin
                    last_len = en_cnt[k];
                    last_ch  = k;
                    en_reads++;
                end
                en_cnt[k] = 0;
            end
            sensor_done[k]  = sensor_enable[k] && ch_delay[k] != 0 && en_cnt[k] >= ch_delay[k] && !ch_err[k];
            sensor_error[k] = sensor_enable[k] && ch_delay[k] != 0 && en_cnt[k] >= ch_delay[k] && ch_err[k];
        end
    end

    // Response monitor.
    always @(negedge clock) begin
        if (host_bus.response_valid) begin
            check("pulse_width", int'(prev_valid), 0);
            got_q.push_back('{c: host_bus.response_command, v: host_bus.response_value, t: cyc});
        end
        prev_valid = host_bus.response_valid;
        if ($countones(sensor_enable) > 1) onehot_bad++;
    end

    function automatic bit data_ok(input int ch);
        logic [39:0] d;
        int s;
        d = ch_data[ch];
        s = (int'(d[39:32]) + int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8])) % 256;
        return s == int'(d[7:0]);
    endfunction

    function automatic logic [39:0] make_data(input bit good);
        int h, hd, t, td, s;
        h  = $urandom_range(0, 99);
        hd = $urandom_range(0, 9);
        t  = $urandom_range(0, 60);
        td = $urandom_range(0, 9);
        s  = (h + hd + t + td) % 256;
        if (!good) s = (s + $urandom_range(1, 255)) % 256;
        return {h[7:0], hd[7:0], t[7:0], td[7:0], s[7:0]};
    endfunction

    // Expected response for a host request, from the command rules.
    task automatic model_req(input int cmd, input int addr, output int rc, output int rv,
                             output int reads, output int len);
        bit fault;
        logic [39:0] d;
        reads = 0; len = 0;
        if (addr >= NS) begin rc = 'hEF; rv = 'hEF; end
        else if (cmd > 6) begin rc = 'h45; rv = 'h45; end
        else if (cmd <= 2) begin
            if (mode_m[addr] != 0) begin rc = 'hFF; rv = 'hFF; end
            else begin
                reads = 1;
                len   = (ch_delay[addr] == 0) ? TMO : ch_delay[addr];
                fault = ch_err[addr] || ch_delay[addr] == 0 || !data_ok(addr);
                d = ch_data[addr];
                if (cmd == 0) begin rc = fault ? 'h1F : 'h07; rv = rc; end
                else if (fault) begin rc = 'h45; rv = 'h45; end
                else if (cmd == 1) begin rc = 'h09; rv = int'(d[23:16]); end
                else begin rc = 'h08; rv = int'(d[39:32]); end
            end
        end else if (cmd <= 4) begin
            mode_m[addr] = cmd - 2;
            rc = 'h0C; rv = addr;
        end else if (mode_m[addr] == cmd - 4) begin
            mode_m[addr] = 0;
            rc = 'h0F; rv = addr;
        end else begin rc = 'hAA; rv = 'hAA; end
    endtask

    task automatic send_req(input int cmd, input int addr);
        @(negedge clock);
        host_bus.request_command = 8'(cmd);
        host_bus.request_address = 8'(addr);
        host_bus.enable = 1'b1;
        @(negedge clock);
        host_bus.enable = 1'b0;
    endtask

    task automatic wait_resp(output rsp_t r, output bit ok);
        ok = 1'b0;
        r = '{c: '0, v: '0, t: 0};
        for (int i = 0; i < 400 && !ok; i++) begin
            if (got_q.size() > 0) begin r = got_q.pop_front(); ok = 1'b1; end
            else @(negedge clock);
        end
        if (!ok) check("resp_wait", 0, 1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 500 && !idle; i++) begin
            @(negedge clock);
            idle = !host_bus.busy;
        end
        if (!idle) check("idle_wait", 0, 1);
    endtask

    task automatic run_req(input int cmd, input int addr);
        int rc, rv, reads, len, nr, t0;
        rsp_t r;
        bit ok;
        model_req(cmd, addr, rc, rv, reads, len);
        nr = en_reads;
        send_req(cmd, addr);
        t0 = cyc;
        check("busy", int'(host_bus.busy), 1);
        wait_resp(r, ok);
        if (ok) begin
            check("rsp_cmd", int'(r.c), rc);
            check("rsp_val", int'(r.v), rv);
            check("latency", r.t - t0, reads ? 1 + len : 1);
        end
        wait_idle();
        check("reads", en_reads - nr, reads);
        if (reads != 0) begin
            check("en_len", last_len, len);
            check("en_ch", last_ch, addr);
        end
        check("hold_cmd", int'(host_bus.response_command), rc);
    endtask

    task automatic expect_cont(input int ch, input bit temp, output int t);
        rsp_t r;
        bit ok;
        logic [39:0] d;
        int rc, rv;
        d = ch_data[ch];
        if (ch_err[ch] || ch_delay[ch] == 0 || !data_ok(ch)) begin rc = 'h45; rv = 'h45; end
        else if (temp) begin rc = 'h0D; rv = int'(d[23:16]); end
        else begin rc = 'h0E; rv = int'(d[39:32]); end
        wait_resp(r, ok);
        t = r.t;
        if (ok) begin
            check("cont_cmd", int'(r.c), rc);
            check("cont_val", int'(r.v), rv);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < NS; k++) mode_m[k] = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        got_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, rv, reads, len, t0, ta, tb, t, r_sel, cmd, addr;
        rsp_t r;
        bit ok;
        host_bus.enable = 1'b0;
        host_bus.request_command = '0;
        host_bus.request_address = '0;
        for (int k = 0; k < NS; k++) begin
            ch_data[k] = make_data(1'b1); ch_delay[k] = 3; ch_err[k] = 1'b0;
            mode_m[k] = 0; en_cnt[k] = 0;
        end

        repeat (3) @(negedge clock);
        check("rst_enable", int'(sensor_enable), 0);
        check("rst_valid", int'(host_bus.response_valid), 0);
        check("rst_cmd", int'(host_bus.response_command), 0);
        check("rst_val", int'(host_bus.response_value), 0);
        check("rst_busy", int'(host_bus.busy), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Directed cases.
        ch_data[1] = 40'h28_00_19_00_41; ch_delay[1] = 10;
        run_req(1, 1);
        ch_data[1] = 40'h28_00_19_00_42;
        run_req(0, 1);
        run_req(2, 1);
        ch_delay[0] = 0;
        run_req(1, 0);
        run_req(1, 7);
        run_req(6, 3);
        run_req(9, 2);

        // Random host requests on idle channels.
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NS; k++) begin
                ch_data[k]  = make_data($urandom_range(0, 3) != 0);
                ch_err[k]   = ($urandom_range(0, 6) == 0);
                ch_delay[k] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
            end
            r_sel = $urandom_range(0, 9);
            if (r_sel <= 2) cmd = r_sel;
            else if (r_sel == 3) cmd = 5;
            else if (r_sel == 4) cmd = 6;
            else if (r_sel == 5) cmd = $urandom_range(7, 255);
            else cmd = $urandom_range(0, 2);
            addr = ($urandom_range(0, 6) == 0) ? $urandom_range(4, 255) : $urandom_range(0, 3);
            run_req(cmd, addr);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        // Strobe during a pending read is dropped.
        ch_data[1] = make_data(1'b1); ch_err[1] = 1'b0; ch_delay[1] = 10;
        model_req(1, 1, rc, rv, reads, len);
        send_req(1, 1);
        t0 = cyc;
        repeat (3) @(negedge clock);
        send_req(0, 3);
        wait_resp(r, ok);
        if (ok) begin
            check("drop_cmd", int'(r.c), rc);
            check("drop_val", int'(r.v), rv);
            check("drop_lat", r.t - t0, 11);
        end
        wait_idle();
        repeat (40) @(negedge clock);
        check("dropped", got_q.size(), 0);

        // Continuous sensing from a fresh period counter.
        do_reset();
        for (int k = 0; k < NS; k++) begin
            ch_data[k] = make_data(1'b1); ch_err[k] = 1'b0;
        end
        ch_delay[0] = 5; ch_delay[2] = 7;
        run_req(3, 0);
        expect_cont(0, 1'b1, t);
        wait_idle();
        run_req(4, 2);
        expect_cont(2, 1'b0, t);
        wait_idle();
        expect_cont(0, 1'b1, ta);
        expect_cont(2, 1'b0, t);
        wait_idle();
        expect_cont(0, 1'b1, tb);
        check("period", tb - ta, LP);
        expect_cont(2, 1'b0, t);
        wait_idle();
        run_req(1, 2);
        run_req(5, 2);
        run_req(5, 0);
        for (int n = 0; n < 3; n++) begin
            expect_cont(2, 1'b0, t);
            wait_idle();
        end
        run_req(6, 2);
        repeat (450) @(negedge clock);
        check("quiet", got_q.size(), 0);

        // Reset in the middle of a read.
        ch_delay[1] = 0;
        send_req(1, 1);
        repeat (5) @(negedge clock);
        check("mid_read_en", int'(sensor_enable), 2);
        #2 reset = 1'b1;
        #1;
        check("arst_enable", int'(sensor_enable), 0);
        check("arst_valid", int'(host_bus.response_valid), 0);
        check("arst_busy", int'(host_bus.busy), 0);
        check("arst_cmd", int'(host_bus.response_command), 0);
        check("arst_val", int'(host_bus.response_value), 0);
        got_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < NS; k++) mode_m[k] = 0;
        repeat (80) @(negedge clock);
        check("no_pulse", got_q.size(), 0);
        check("onehot", onehot_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sensor_hub.md
# sensor_hub

Parametrised successor to the single-sensor command handler. It serves host requests (command + address) for up to NUM_SENSORS 40-bit sensor channels of DHT11 type over one shared response port. It runs independent per-channel continuous sensing, validates checksums, bounds every read with a timeout and rejects out-of-range addresses. It sits between the UART command decoder and the per-sensor communication modules.

## Interface
- NUM_SENSORS, 4: channels; 1..32.
- LOOP_PERIOD_CYCLES, 100000000: continuous-mode period (2 s at 50 MHz).
- TIMEOUT_CYCLES, 2500000: maximum READ duration before a forced error (50 ms).
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  request strobe; a request is taken on the rising edge of enable (0 in the previous cycle, 1 in the current cycle).
- request_command  in  8  command code, sampled with enable.
- request_address  in  8  channel index, sampled with enable.
- sensor_data  in  40*NUM_SENSORS  channel k occupies bits [40k+39:40k]; byte order is hum_int, hum_dec, temp_int, temp_dec, checksum (MSB first).
- sensor_error  in  NUM_SENSORS  per-channel protocol error.
- sensor_done  in  NUM_SENSORS  per-channel data-ready.
- sensor_enable  out  NUM_SENSORS  one-hot read request; at most one bit high.
- response_valid  out  1  one-cycle pulse; the response fields are valid in that cycle.
- response_command  out  8  response code; held until the next response.
- response_value  out  8  response payload; held until the next response.
- busy  out  1  high while a request is pending or the FSM is not in IDLE.

## Operation
- Request latch: one-deep. A strobe is accepted only when no request is pending. A strobe that arrives while a request is pending is dropped silently.
- Per-channel mode register: OFF, CONT_TEMP or CONT_HUM. Per-channel due flag.
- Global period counter: counts 0..LOOP_PERIOD_CYCLES-1. On wrap, it sets the due flag of every channel whose mode is not OFF.
- FSM states: IDLE, READ, SEND, GAP.
- IDLE: a pending request has priority. Otherwise the FSM serves the due channel found by a round-robin search starting after the last channel served. Otherwise it stays in IDLE.
- Immediate responses go IDLE->SEND with no read:
  - address >= NUM_SENSORS: EF/EF.
  - unknown command (>06): 45/45.
  - 05 or 06 on a channel whose mode is OFF: AA/AA.
  - 05 on a CONT_TEMP channel, or 06 on a CONT_HUM channel: mode becomes OFF, due flag clears, response 0F/address.
  - 05 or 06 that does not match the channel's current continuous mode: AA/AA.
  - 00/01/02 on a channel not in OFF mode: FF/FF.
  - 03/04: set mode to CONT_TEMP/CONT_HUM, set due flag, response 0C/address. Issuing 03/04 on an active channel overwrites its mode.
- Read commands go to READ: 00/01/02 on an OFF channel, and service of a due channel.
- READ: raises sensor_enable[ch] and runs the timeout counter. It exits on the first edge that samples sensor_done[ch]=1, sensor_error[ch]=1 or timeout.
- Result evaluation:
  - fault = sensor_error | timeout | checksum mismatch.
  - Checksum is good when byte0 == (byte1+byte2+byte3+byte4) mod 256, using an 8-bit wrapping sum.
  - 00: 07/07 if no fault, else 1F/1F.
  - 01: 09/temp_int. 02: 08/hum_int.
  - Continuous service: 0D/temp_int or 0E/hum_int. The due flag clears.
  - Any fault on 01, 02 or a continuous service: 45/45. The mode is kept.
- SEND: response_valid=1 for exactly one cycle. The pending request clears, or the due flag clears for continuous service.
- GAP: sensor_enable all 0 for 2 cycles, then IDLE. This guarantees a fresh enable rising edge for the next read.

## Timing
- Reset values: sensor_enable=0, response_valid=0, response_command=00, response_value=00, busy=0. All modes OFF, all due flags 0, period and timeout counters 0, FSM in IDLE, round-robin pointer at NUM_SENSORS-1.
- A strobe is sampled at edge T. busy=1 from T+1.
- Immediate command: SEND at T+1, so response_valid is high in the cycle after T+1.
- Read command: sensor_enable[ch] rises at T+1. If the exit condition is sampled at edge D, sensor_enable falls at D and response_valid is high in cycle D..D+1. Response registers load at D.
- Timeout: exit occurs TIMEOUT_CYCLES cycles after READ entry.
- Period wrap during READ: due flags still set. They are served after GAP.
- Strobe during READ or SEND: latched if no request is pending. It is served before any due channel.
- A 05/06 stop arriving while that channel's continuous read is in progress: the in-flight read still completes, sends its 0D/0E, and then the stop is processed.
- Asserting reset mid-READ: sensor_enable drops asynchronously and no response is issued.

## Test plan
- Single read: ch1 data 0x28_00_19_00_41 (hum 40, temp 25, checksum 0x41), command 01 address 1, sensor_done after 10 cycles -> one 09/19 pulse, sensor_enable[1] high for exactly 10 cycles.
- Bad checksum: byte0=0x42, command 00 -> 1F/1F. The same data with command 02 -> 45/45.
- Timeout: TIMEOUT_CYCLES=50, done never asserted, command 01 addr 0 -> 45/45 at READ entry+50 cycles.
- Invalid address: NUM_SENSORS=4, command 01 addr 7 -> EF/EF. sensor_enable stays 0.
- Continuous: LOOP_PERIOD_CYCLES=200, 03 on ch0 and 04 on ch2 -> 0C acks, then per period one 0D/temp from ch0 and one 0E/hum from ch2, ch0 first. Command 05 ch0 -> 0F/00, and ch0 gets no further 0D.
- Conflicts: 01 on a CONT_TEMP channel -> FF/FF. 06 on an OFF channel -> AA/AA. Reset asserted mid-READ -> outputs at reset values and no pulse.
